// File: rtl/hex_counter_display.sv
// Multi-digit hex up/down counter with a prescaled step tick and per-digit
// active-low 7-segment outputs, with optional leading-zero blanking.
module hex_counter_display #(
  parameter int unsigned DIV    = 50_000_000,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  tick,
  output logic                  wrap
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned HW = 7 * DIGITS;
  localparam logic [PW-1:0] PresLast = PW'(DIV - 1);
  localparam logic [6:0] SegBlank = 7'h7F;

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [HW-1:0] hex_q, hex_d;
  logic          count_max, count_zero;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Tick is decoded straight from the prescaler register so it lines up with
  // the cycle in which the prescaler rolls over.
  assign tick       = en && (presc_q == PresLast);
  assign count_max  = &count_q;
  assign count_zero = ~|count_q;

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      // A coincident tick is dropped: the loaded value wins and the interval restarts.
      presc_d = '0;
      count_d = load_val;
    end else begin
      if (en) begin
        presc_d = (presc_q == PresLast) ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        if (dir) begin
          count_d = count_q + 1'b1;
          wrap_d  = count_max;
        end else begin
          count_d = count_q - 1'b1;
          wrap_d  = count_zero;
        end
      end
    end
  end

  // Scan from the top digit down; a digit blanks only while everything above
  // it (and itself) is zero. Digit 0 always shows.
  always_comb begin
    logic upper_zero;
    hex_d      = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (count_q[4*i +: 4] == 4'h0);
      if (blank_lz && upper_zero && (i != 0)) begin
        hex_d[7*i +: 7] = SegBlank;
      end else begin
        hex_d[7*i +: 7] = seg7(count_q[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      hex_q   <= {DIGITS{7'h40}};
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign hex   = hex_q;

endmodule

// File: tb/tb_hex_counter_display.sv
// Bench for hex_counter_display: DIV=4/DIGITS=2 instance checked against a
// cycle-level arithmetic model, plus a DIV=1 instance for the every-cycle case.
module tb_hex_counter_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, dir = 1'b0, load = 1'b0, blz = 1'b0;
  logic [7:0]  lv = '0;
  logic [7:0]  count;
  logic [13:0] hex;
  logic        tick, wrap;

  logic        d1_en = 1'b0, d1_dir = 1'b0;
  logic [7:0]  d1_count;
  logic [13:0] d1_hex;
  logic        d1_tick, d1_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_count = 0;
  int          m_phase = 0;
  bit          m_wrap  = 1'b0;
  logic [13:0] m_hex   = 14'h2040;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [7:0]  lv;
    bit          blz;
    logic [13:0] exp_hex;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  hex_counter_display #(.DIV(DIV), .DIGITS(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (lv),
    .blank_lz (blz),
    .count    (count),
    .hex      (hex),
    .tick     (tick),
    .wrap     (wrap)
  );

  hex_counter_display #(.DIV(1), .DIGITS(2)) u_div1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (d1_en),
    .dir      (d1_dir),
    .load     (1'b0),
    .load_val (8'h00),
    .blank_lz (1'b0),
    .count    (d1_count),
    .hex      (d1_hex),
    .tick     (d1_tick),
    .wrap     (d1_wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] hex_of(input int v, input bit b);
    logic [13:0] r;
    int          upper;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      upper = v >> (4 * i);
      if (i > 0 && b && upper == 0) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = seg_tbl[upper & 15];
    end
    return r;
  endfunction

  // One clock cycle: apply inputs, check tick, advance model, check registered outputs.
  task automatic drive(input bit e, input bit d, input bit l, input int v, input bit b);
    int prev;
    bit t;
    en = e; dir = d; load = l; lv = 8'(v); blz = b;
    #1;
    t = e && (m_phase == DIV - 1);
    chk("tick", {31'b0, tick}, {31'b0, t});
    prev  = m_count;
    m_hex = hex_of(prev, b);
    m_wrap = 1'b0;
    if (l) begin
      m_count = v & 255;
      m_phase = 0;
    end else begin
      if (e) m_phase = (m_phase + 1) % DIV;
      if (t) begin
        if (d) begin
          m_count = (prev + 1) % 256;
          m_wrap  = (prev == 255);
        end else begin
          m_count = (prev + 255) % 256;
          m_wrap  = (prev == 0);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("wrap", {31'b0, wrap}, {31'b0, m_wrap});
    chk("hex", 32'(hex), 32'(m_hex));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_hex", 32'(hex), 32'h2040);
    chk("rst_tick", {31'b0, tick}, 32'h0);
    chk("rst_wrap", {31'b0, wrap}, 32'h0);
    m_count = 0; m_phase = 0; m_wrap = 1'b0; m_hex = 14'h2040;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d1_exp;
    bit d1_wexp;

    vecs[0]  = '{8'h05, 1'b1, {7'h7F, 7'h12}};
    vecs[1]  = '{8'h00, 1'b1, {7'h7F, 7'h40}};
    vecs[2]  = '{8'h50, 1'b1, {7'h12, 7'h40}};
    vecs[3]  = '{8'h00, 1'b0, {7'h40, 7'h40}};
    vecs[4]  = '{8'hFF, 1'b0, {7'h0E, 7'h0E}};
    vecs[5]  = '{8'h3A, 1'b0, {7'h30, 7'h08}};
    vecs[6]  = '{8'h9C, 1'b1, {7'h10, 7'h46}};
    vecs[7]  = '{8'h7D, 1'b0, {7'h78, 7'h21}};
    vecs[8]  = '{8'h1B, 1'b1, {7'h79, 7'h03}};
    vecs[9]  = '{8'h68, 1'b0, {7'h02, 7'h00}};
    vecs[10] = '{8'hE4, 1'b1, {7'h06, 7'h19}};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset in the middle of a count, with the counter enabled.
    drive(0, 1, 1, 'h3A, 0);
    drive(1, 1, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 32'h3A);
    do_reset();

    // Count up from reset: first tick on the 4th enabled cycle.
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
    chk("t2_no_step_yet", 32'(count), 32'h0);
    drive(1, 1, 0, 0, 0);
    chk("t2_first_step", 32'(count), 32'h1);
    drive(1, 1, 0, 0, 0);
    chk("t2_hex_01", 32'(hex), 32'h2079);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0);
    chk("t2_held", 32'(count), 32'h1);

    // Up wrap FF -> 00.
    drive(0, 1, 1, 'hFF, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0);
    chk("t3_wrap_up", {31'b0, wrap}, 32'h1);
    chk("t3_count", 32'(count), 32'h0);
    drive(0, 1, 0, 0, 0);
    chk("t3_wrap_once", {31'b0, wrap}, 32'h0);
    chk("t3_hex", 32'(hex), 32'h2040);

    // Down wrap 00 -> FF.
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0);
    chk("t4_wrap_down", {31'b0, wrap}, 32'h1);
    chk("t4_count", 32'(count), 32'hFF);
    drive(0, 0, 0, 0, 0);
    chk("t4_hex", 32'(hex), 32'h070E);

    // Segment table and leading-zero blanking.
    foreach (vecs[k]) begin
      drive(0, 1, 1, vecs[k].lv, vecs[k].blz);
      drive(0, 1, 0, 0, vecs[k].blz);
      chk($sformatf("vec%0d_hex", k), 32'(hex), 32'(vecs[k].exp_hex));
    end

    // Load coinciding with a tick: step lost, next tick a full interval later.
    drive(0, 1, 1, 'h10, 0);
    while (m_phase != DIV - 1) drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 'h42, 0);
    chk("t6_load_wins", 32'(count), 32'h42);
    chk("t6_no_wrap", {31'b0, wrap}, 32'h0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0);
    chk("t6_hold", 32'(count), 32'h42);
    drive(1, 1, 0, 0, 0);
    chk("t6_step", 32'(count), 32'h43);

    // Randomised traffic against the model, biased toward enabled counting near the wraps.
    for (int i = 0; i < 400; i++) begin
      bit l;
      int v;
      l = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : (($urandom_range(0, 1) == 1) ? 254 : 1);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, l, v, $urandom_range(0, 1) == 1);
      if (i == 200) do_reset();
    end

    // DIV=1: every enabled cycle is a step.
    d1_exp = 0;
    for (int i = 0; i < 40; i++) begin
      d1_en  = ($urandom_range(0, 3) != 0);
      d1_dir = (i < 5) ? 1'b0 : ($urandom_range(0, 1) == 1);
      #1;
      chk("d1_tick", {31'b0, d1_tick}, {31'b0, d1_en});
      d1_wexp = 1'b0;
      if (d1_en) begin
        d1_wexp = d1_dir ? (d1_exp == 255) : (d1_exp == 0);
        d1_exp  = d1_dir ? (d1_exp + 1) % 256 : (d1_exp + 255) % 256;
      end
      @(posedge clk);
      #1;
      chk("d1_count", 32'(d1_count), 32'(d1_exp));
      chk("d1_wrap", {31'b0, d1_wrap}, {31'b0, d1_wexp});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
